cache_fill_arbiter: RTL
=======================

// Module: cache_fill_arbiter
// PURPOSE
//  Arbitrates six data sources for cache write (fill) bursts: AHB, SRAM1, SRAM2, SD1, SD2, SD3.
//  Drives the 3-bit select code of the cache data-in mux, plus cache write enable and word address.
//  Sits between the RAID5 source controllers and the cache array. Each grant covers one burst of BURST_LEN words.
// PARAMETERS
//  ADDR_W     8    cache word-address width
//  BURST_LEN  8    words per fill burst (>=1)
//  TIMEOUT    255  idle cycles allowed between beats before the burst aborts (>=1)
// PORTS
//  clk        in   1         clock; all state updates on the rising edge
//  rst        in   1         synchronous, active-high reset
//  req        in   6         fill request; bit i = source i (0=AHB,1=SRAM1,2=SRAM2,3=SD1,4=SD2,5=SD3)
//  req_addr   in   6*ADDR_W  per-source burst base address; slice i = [i*ADDR_W +: ADDR_W]
//  src_valid  in   6         source i presents a valid data word this cycle
//  gnt        out  6         one-hot grant, registered
//  select_out out  3         mux code: 0 = none, i+1 = source i
//  cache_we   out  1         cache write strobe for the current word
//  cache_addr out  ADDR_W    cache word address for the current word
//  fill_done  out  6         one-cycle pulse at the end of source i's burst
//  fill_err   out  1         one-cycle pulse with fill_done when the burst ended by timeout
//  busy       out  1         high in any state other than IDLE
// BEHAVIOUR
//  Reset values: state=IDLE, gnt=0, select_out=0, cache_we=0, cache_addr=0, fill_done=0, fill_err=0,
//   busy=0, rr_ptr=0, beat=0, idle_cnt=0. A reset mid-burst abandons the burst and pulses no fill_done.
//  FSM states: IDLE, XFER, DONE.
//   IDLE: if req!=0, select the winner round-robin, starting at rr_ptr and scanning upward with wrap.
//    Register gnt, win, base=req_addr[win], beat=0 and idle_cnt=0, then go to XFER.
//    Latency: req sampled in cycle N; gnt and select_out valid in cycle N+1.
//   XFER: select_out=win+1 and cache_addr=base+beat (modulo 2^ADDR_W, wraps silently).
//    cache_we=src_valid[win], combinational within the cycle.
//    src_valid of non-granted sources is ignored.
//    On a valid beat: beat++ and idle_cnt=0. Otherwise idle_cnt++.
//    Valid beat with beat==BURST_LEN-1 -> DONE with fill_err=0.
//    idle_cnt reaching TIMEOUT -> DONE with fill_err=1. No write occurs in the timeout cycle.
//    Deasserting req during XFER is ignored; the burst runs to completion or timeout.
//   DONE (1 cycle): fill_done[win]=1 and fill_err as latched; gnt=0, select_out=0, cache_we=0.
//    Set rr_ptr=(win+1)%6, then go to IDLE.
//    A requester must drop req in its fill_done cycle. A req still high in the next IDLE cycle counts as a new request.
//  Outside XFER: select_out=0 and cache_we=0 at all times.
//  Simultaneous requests are resolved by round-robin only. A new req arriving during XFER waits for IDLE.
//  Minimum burst occupancy: 1 (grant) + BURST_LEN + 1 (DONE) cycles. Back-to-back grants are 1 IDLE cycle apart.
// CONFIGURATION
//  AHB_PRIORITY_EN defined: in IDLE, req[0] (AHB) wins unconditionally over all others.
//   rr_ptr is updated only when a non-AHB source wins.
//  AHB_PRIORITY_EN undefined: AHB takes part in the round-robin like every other source.
// STRUCTURE
//  Package cache_fill_pkg holds:
//   - src_sel_t enum: SEL_NONE=0, SEL_AHB=1, SEL_SRAM1=2, SEL_SRAM2=3, SEL_SD1=4, SEL_SD2=5, SEL_SD3=6
//   - fill_state_t enum: IDLE, XFER, DONE
//   - NUM_SRC=6
//  Sub-module rr_pick6: combinational round-robin picker.
//   Inputs: req[5:0], ptr[2:0], plus the ahb_prio strap.
//   Outputs: any, idx[2:0].
//  The FSM, counters and output registers stay in cache_fill_arbiter.
// TESTING
//  1. Reset with req=6'h3F held -> all outputs 0 during reset.
//     After release, gnt=6'h01 and select_out=1 exactly 1 cycle later.
//  2. SRAM1 req, addr=8'h10, src_valid every cycle -> 8 writes at 8'h10..8'h17.
//     Then fill_done=6'h02 and fill_err=0.
//  3. req=6'h3F held, each source toggling req off/on around its fill_done -> grant order 0,1,2,3,4,5,0.
//     With AHB_PRIORITY_EN, the order is 0,0,0... while req[0] is held.
//  4. SD2 granted, src_valid stops after 3 beats -> TIMEOUT idle cycles later, fill_done=6'h10 and fill_err=1.
//     Only 3 writes occur.
//  5. base=8'hFE, BURST_LEN=8 -> cache_addr sequence FE,FF,00..05.
//     Non-granted src_valid pulses produce no cache_we.
//  6. rst asserted at beat 4 of an SD3 burst -> next cycle all outputs 0 and no fill_done pulse.
//     After release, rr_ptr=0 and AHB wins if requesting.

Source files
------------

// File: rtl/cache_fill_pkg.sv
// rtl/cache_fill_pkg.sv - shared types and constants for the cache fill arbiter
package cache_fill_pkg;

  localparam int NUM_SRC = 6;

  typedef enum logic [2:0] {
    SEL_NONE  = 3'd0,
    SEL_AHB   = 3'd1,
    SEL_SRAM1 = 3'd2,
    SEL_SRAM2 = 3'd3,
    SEL_SD1   = 3'd4,
    SEL_SD2   = 3'd5,
    SEL_SD3   = 3'd6
  } src_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/cache_fill_arbiter_rr_pick6.sv
// rtl/cache_fill_arbiter_rr_pick6.sv - combinational round-robin picker over six requesters
module rr_pick6
  import cache_fill_pkg::*;
(
  input  logic [5:0] req,
  input  logic [2:0] ptr,
  input  logic       ahb_prio,
  output logic       any,
  output logic [2:0] idx
);

  logic       found;
  logic [3:0] pos;

  always_comb begin
    any   = |req;
    idx   = 3'd0;
    found = 1'b0;
    pos   = 4'd0;
    // Scan upward from ptr with wrap; the first requester seen wins.
    for (int k = 0; k < NUM_SRC; k++) begin
      pos = 4'(ptr) + 4'(k);
      if (pos >= 4'(NUM_SRC)) pos = pos - 4'(NUM_SRC);
      if (!found && req[pos[2:0]]) begin
        idx   = pos[2:0];
        found = 1'b1;
      end
    end
    if (ahb_prio && req[0]) idx = 3'd0;
  end

endmodule

// File: rtl/cache_fill_arbiter.sv
// rtl/cache_fill_arbiter.sv - six-source cache fill burst arbiter
// AHB_PRIORITY_EN: when defined, AHB (req[0]) always wins in IDLE.
module cache_fill_arbiter
  import cache_fill_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            req,
  input  logic [6*ADDR_W-1:0]   req_addr,
  input  logic [5:0]            src_valid,
  output logic [5:0]            gnt,
  output logic [2:0]            select_out,
  output logic                  cache_we,
  output logic [ADDR_W-1:0]     cache_addr,
  output logic [5:0]            fill_done,
  output logic                  fill_err,
  output logic                  busy
);

  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

`ifdef AHB_PRIORITY_EN
  localparam logic AHB_PRIO = 1'b1;
`else
  localparam logic AHB_PRIO = 1'b0;
`endif

  fill_state_t         state_q, state_d;
  logic [5:0]          gnt_q, gnt_d;
  logic [2:0]          win_q, win_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [2:0]          rr_ptr_q, rr_ptr_d;
  logic                err_q, err_d;

  logic                pick_any;
  logic [2:0]          pick_idx;

  rr_pick6 u_pick (
    .req      (req),
    .ptr      (rr_ptr_q),
    .ahb_prio (AHB_PRIO),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      win_q      <= '0;
      base_q     <= '0;
      beat_q     <= '0;
      idle_cnt_q <= '0;
      rr_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      win_q      <= win_d;
      base_q     <= base_d;
      beat_q     <= beat_d;
      idle_cnt_q <= idle_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    win_d      = win_q;
    base_d     = base_q;
    beat_d     = beat_q;
    idle_cnt_d = idle_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = XFER;
          win_d      = pick_idx;
          gnt_d      = 6'b1 << pick_idx;
          base_d     = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          beat_d     = '0;
          idle_cnt_d = '0;
          err_d      = 1'b0;
        end
      end
      XFER: begin
        if (src_valid[win_q]) begin
          beat_d     = beat_q + 1'b1;
          idle_cnt_d = '0;
          if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
            state_d = DONE;
            gnt_d   = '0;
            err_d   = 1'b0;
          end
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
          // The cycle that brings the idle count to TIMEOUT is the abort cycle.
          if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
            state_d = DONE;
            gnt_d   = '0;
            err_d   = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!(AHB_PRIO && win_q == 3'd0)) begin
          rr_ptr_d = (win_q == 3'(NUM_SRC - 1)) ? 3'd0 : win_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt        = gnt_q;
    busy       = (state_q != IDLE);
    select_out = SEL_NONE;
    cache_we   = 1'b0;
    cache_addr = '0;
    fill_done  = '0;
    fill_err   = 1'b0;
    if (state_q == XFER) begin
      select_out = win_q + 3'(SEL_AHB);
      cache_we   = src_valid[win_q];
      cache_addr = base_q + ADDR_W'(beat_q);
    end
    if (state_q == DONE) begin
      fill_done = 6'b1 << win_q;
      fill_err  = err_q;
    end
  end

endmodule
